// File: rtl/dmem_responder_pkg.sv
// Shared core package: RV32I load/store funct3 codes,
// default data-memory depth and byte-lane helpers.
package dmem_responder_pkg;

  localparam int DMEM_DEPTH_WORDS = 1024;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } acc_size_e;

  // Access size implied by a funct3 code (loads and stores)
  function automatic acc_size_e f3_size(
    input logic [2:0] f3
  );
    acc_size_e sz;
    unique case (f3)
      F3_LB, F3_LBU: sz = SZ_BYTE;
      F3_LH, F3_LHU: sz = SZ_HALF;
      F3_LW:         sz = SZ_WORD;
      default:       sz = SZ_NONE;
    endcase
    return sz;
  endfunction

  // Byte-lane enables of a store; halves and words
  // ignore the low offset bits (forced alignment)
  function automatic logic [3:0] store_be(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] be;
    unique case (f3)
      F3_SB:   be = 4'b0001 << off;
      F3_SH:   be = off[1] ? 4'b1100 : 4'b0011;
      F3_SW:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Right-aligned store data replicated onto every lane
  function automatic logic [31:0] store_lanes(
    input logic [2:0]  f3,
    input logic [31:0] wd
  );
    logic [31:0] v;
    unique case (f3)
      F3_SB:   v = {4{wd[7:0]}};
      F3_SH:   v = {2{wd[15:0]}};
      default: v = wd;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/dmem_responder_sram.sv
// Data-memory array: DEPTH_WORDS x 32, byte enables,
// synchronous read-first port with resettable read register.
module dmem_sram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Byte-lane writes; the array itself is never reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) begin
        mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Read register samples the pre-write word every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word stores, extended loads.
// Optional misalignment trap: define DMEM_MISALIGN_TRAP_EN.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_mem_write_M,
  input  logic [DATA_WIDTH-1:0] i_data_addr_M,
  input  logic [DATA_WIDTH-1:0] i_write_data_M,
  input  logic [2:0]            i_funct3_MEM,
  output logic [DATA_WIDTH-1:0] o_read_data_M,
  output logic                  o_misaligned_WB
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [AW-1:0]   idx;
  logic [1:0]      off;
  logic            mis_d;
  logic [3:0]      be;
  logic [31:0]     wlanes;
  logic [31:0]     rword;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic            mis_q;
  logic [7:0]      bsel;
  logic [15:0]     hsel;
  logic [DATA_WIDTH-1:0] rd_d;
  logic            unused_addr;

  assign idx    = i_data_addr_M[AW+1:2];
  assign off    = i_data_addr_M[1:0];
  assign unused_addr = ^i_data_addr_M[DATA_WIDTH-1:AW+2];
  assign wlanes = store_lanes(i_funct3_MEM,
                              i_write_data_M[31:0]);

  // Misalignment detection for the access in this cycle
  always_comb begin
    mis_d = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    unique case (f3_size(i_funct3_MEM))
      SZ_HALF: mis_d = off[0];
      SZ_WORD: mis_d = (off != 2'b00);
      default: mis_d = 1'b0;
    endcase
`endif
  end

  // Store lane enables; reset and misalignment block writes
  always_comb begin
    be = '0;
    if (i_mem_write_M && !rst && !mis_d) begin
      be = store_be(i_funct3_MEM, off);
    end
  end

  dmem_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_sram (
    .clk     (clk),
    .rst     (rst),
    .addr_i  (idx),
    .be_i    (be),
    .wdata_i (wlanes),
    .rdata_o (rword)
  );

  // Pipeline the access shape alongside the read word
  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q  <= '0;
      off_q <= '0;
      mis_q <= 1'b0;
    end else begin
      f3_q  <= i_funct3_MEM;
      off_q <= off;
      mis_q <= mis_d;
    end
  end

  // Lane select and sign/zero extension of the read word
  always_comb begin
    rd_d = '0;
    unique case (off_q)
      2'd0:    bsel = rword[7:0];
      2'd1:    bsel = rword[15:8];
      2'd2:    bsel = rword[23:16];
      default: bsel = rword[31:24];
    endcase
    hsel = off_q[1] ? rword[31:16] : rword[15:0];
    unique case (f3_q)
      F3_LB:  rd_d = {{(DATA_WIDTH-8){bsel[7]}}, bsel};
      F3_LH:  rd_d = {{(DATA_WIDTH-16){hsel[15]}}, hsel};
      F3_LW:  rd_d = DATA_WIDTH'(rword);
      F3_LBU: rd_d = {{(DATA_WIDTH-8){1'b0}}, bsel};
      F3_LHU: rd_d = {{(DATA_WIDTH-16){1'b0}}, hsel};
      default: rd_d = '0;
    endcase
`ifdef DMEM_MISALIGN_TRAP_EN
    if (mis_q) begin
      rd_d = '0;
    end
`endif
  end

  assign o_read_data_M = rd_d;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign o_misaligned_WB = mis_q;
`else
  assign o_misaligned_WB = 1'b0 & mis_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed cases plus a
// randomized run against a byte-addressed reference model.
module tb_dmem_responder;

  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int BYTES = 4 * DEPTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [DW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [2:0]    f3;
  logic [DW-1:0] rdata;
  logic          mis;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mb [BYTES];

  dmem_responder #(
    .DATA_WIDTH  (DW),
    .DEPTH_WORDS (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_mem_write_M   (we),
    .i_data_addr_M   (addr),
    .i_write_data_M  (wdata),
    .i_funct3_MEM    (f3),
    .o_read_data_M   (rdata),
    .o_misaligned_WB (mis)
  );

  always #5 clk = ~clk;

  // Reference: memory as bytes; loads read before the store lands
  function automatic void model(
    input  bit          r,
    input  bit          w,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [2:0]  f,
    output logic [31:0] erd,
    output logic        emis
  );
    int unsigned ba;
    int unsigned base;
    int          nb;
    bit          bad;
    logic [31:0] v;
    ba  = a % BYTES;
    nb  = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    bad = 0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((f == 3'b001 || f == 3'b101 || f == 3'b010) &&
        (ba % nb) != 0)
      bad = 1;
`endif
    base = ba - (ba % nb);
    v = 0;
    for (int i = 0; i < nb; i++)
      v = v | (32'(mb[base + i]) << (8 * i));
    case (f)
      3'b000: erd = 32'(signed'(v[7:0]));
      3'b001: erd = 32'(signed'(v[15:0]));
      3'b010: erd = v;
      3'b100: erd = {24'd0, v[7:0]};
      3'b101: erd = {16'd0, v[15:0]};
      default: erd = 0;
    endcase
    emis = bad;
    if (bad) erd = 0;
    if (r) begin
      erd  = 0;
      emis = 0;
    end
    if (w && !r && !bad && f[2] == 1'b0 && f[1:0] != 2'b11)
      for (int i = 0; i < nb; i++)
        mb[base + i] = d[8*i +: 8];
  endfunction

  // One access cycle; returns DUT and model results
  task automatic step(
    input  bit          r,
    input  bit          w,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [2:0]  f,
    output logic [31:0] rd,
    output logic        ms,
    output logic [31:0] erd,
    output logic        ems
  );
    rst = r; we = w; addr = a; wdata = d; f3 = f;
    model(r, w, a, d, f, erd, ems);
    @(posedge clk);
    #1;
    rd = rdata;
    ms = mis;
    rst = 0; we = 0; f3 = 3'b011;
  endtask

  task automatic test_reset();
    logic [31:0] rd, erd;
    logic ms, ems;
    step(1, 0, 0, 0, 3'b010, rd, ms, erd, ems);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_rd got %h want 0", rd);
    end
    n_cmp++;
    if (ms !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mis got %b want 0", ms);
    end
  endtask

  task automatic preload();
    logic [31:0] rd, erd;
    logic ms, ems;
    for (int i = 0; i < 64; i++)
      step(0, 1, 32'(4 * i), 0, 3'b010, rd, ms, erd, ems);
  endtask

  task automatic test_word_byte();
    logic [31:0] rd, erd;
    logic ms, ems;
    step(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, rd, ms, erd, ems);
    step(0, 0, 32'h10, 0, 3'b010, rd, ms, erd, ems);
    n_cmp++;
    if (rd !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL lw_10 got %h want deadbeef", rd);
    end
    step(0, 0, 32'h13, 0, 3'b000, rd, ms, erd, ems);
    n_cmp++;
    if (rd !== 32'hFFFFFFDE) begin
      n_bad++;
      $display("FAIL lb_13 got %h want ffffffde", rd);
    end
    step(0, 0, 32'h13, 0, 3'b100, rd, ms, erd, ems);
    n_cmp++;
    if (rd !== 32'h000000DE) begin
      n_bad++;
      $display("FAIL lbu_13 got %h want 000000de", rd);
    end
  endtask

  task automatic test_partial_stores();
    logic [31:0] rd, erd;
    logic ms, ems;
    step(0, 1, 32'h21, 32'h5A, 3'b000, rd, ms, erd, ems);
    step(0, 0, 32'h20, 0, 3'b010, rd, ms, erd, ems);
    n_cmp++;
    if (rd !== 32'h00005A00) begin
      n_bad++;
      $display("FAIL sb_21 got %h want 00005a00", rd);
    end
    step(0, 1, 32'h22, 32'h8001, 3'b001, rd, ms, erd, ems);
    step(0, 0, 32'h22, 0, 3'b001, rd, ms, erd, ems);
    n_cmp++;
    if (rd !== 32'hFFFF8001) begin
      n_bad++;
      $display("FAIL lh_22 got %h want ffff8001", rd);
    end
    step(0, 0, 32'h22, 0, 3'b101, rd, ms, erd, ems);
    n_cmp++;
    if (rd !== 32'h00008001) begin
      n_bad++;
      $display("FAIL lhu_22 got %h want 00008001", rd);
    end
    step(0, 0, 32'h20, 0, 3'b010, rd, ms, erd, ems);
    n_cmp++;
    if (rd !== 32'h80015A00) begin
      n_bad++;
      $display("FAIL cumul_20 got %h want 80015a00", rd);
    end
  endtask

  task automatic test_read_first();
    logic [31:0] rd, erd;
    logic ms, ems;
    step(0, 1, 32'h30, 32'h22222222, 3'b010, rd, ms, erd, ems);
    step(0, 1, 32'h30, 32'h11111111, 3'b010, rd, ms, erd, ems);
    n_cmp++;
    if (rd !== 32'h22222222) begin
      n_bad++;
      $display("FAIL rf_old got %h want 22222222", rd);
    end
    step(0, 0, 32'h30, 0, 3'b010, rd, ms, erd, ems);
    n_cmp++;
    if (rd !== 32'h11111111) begin
      n_bad++;
      $display("FAIL rf_new got %h want 11111111", rd);
    end
  endtask

  task automatic test_reset_store();
    logic [31:0] rd, erd;
    logic ms, ems;
    step(0, 1, 32'h44, 32'h12345678, 3'b010, rd, ms, erd, ems);
    step(0, 1, 32'h40, 32'h0BADF00D, 3'b010, rd, ms, erd, ems);
    step(1, 1, 32'h40, 32'hCAFEBABE, 3'b010, rd, ms, erd, ems);
    n_cmp++;
    if (rd !== 32'h0 || ms !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_out got %h/%b want 0/0", rd, ms);
    end
    step(0, 0, 32'h40, 0, 3'b010, rd, ms, erd, ems);
    n_cmp++;
    if (rd !== 32'h0BADF00D) begin
      n_bad++;
      $display("FAIL rst_nowr got %h want 0badf00d", rd);
    end
    step(0, 0, 32'h44, 0, 3'b010, rd, ms, erd, ems);
    n_cmp++;
    if (rd !== 32'h12345678) begin
      n_bad++;
      $display("FAIL rst_keep got %h want 12345678", rd);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd, erd;
    logic ms, ems;
    step(0, 1, 32'h42, 32'hAAAA5555, 3'b010, rd, ms, erd, ems);
`ifdef DMEM_MISALIGN_TRAP_EN
    n_cmp++;
    if (ms !== 1'b1 || rd !== 32'h0) begin
      n_bad++;
      $display("FAIL mis_flag got %h/%b want 0/1", rd, ms);
    end
    step(0, 0, 32'h40, 0, 3'b010, rd, ms, erd, ems);
    n_cmp++;
    if (ms !== 1'b0 || rd !== 32'h0BADF00D) begin
      n_bad++;
      $display("FAIL mis_nowr got %h/%b want 0badf00d/0",
               rd, ms);
    end
`else
    n_cmp++;
    if (ms !== 1'b0 || rd !== 32'h0BADF00D) begin
      n_bad++;
      $display("FAIL mis_old got %h/%b want 0badf00d/0",
               rd, ms);
    end
    step(0, 0, 32'h40, 0, 3'b010, rd, ms, erd, ems);
    n_cmp++;
    if (ms !== 1'b0 || rd !== 32'hAAAA5555) begin
      n_bad++;
      $display("FAIL mis_align got %h/%b want aaaa5555/0",
               rd, ms);
    end
`endif
  endtask

  task automatic test_alias();
    logic [31:0] rd, erd;
    logic ms, ems;
    step(0, 1, 32'(BYTES + 8), 32'h600DCAFE, 3'b010,
         rd, ms, erd, ems);
    step(0, 0, 32'h8, 0, 3'b010, rd, ms, erd, ems);
    n_cmp++;
    if (rd !== 32'h600DCAFE) begin
      n_bad++;
      $display("FAIL alias_8 got %h want 600dcafe", rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, d;
    logic ms, ems;
    for (int i = 0; i < 400; i++) begin
      a = {$urandom_range(0, 1048575) & 20'hFFFFF, 4'h0,
           8'($urandom_range(0, 255))};
      d = $urandom;
      step(0, 1'($urandom_range(0, 1)), a, d,
           3'($urandom_range(0, 7)), rd, ms, erd, ems);
      n_cmp++;
      if (rd !== erd || ms !== ems) begin
        n_bad++;
        $display("FAIL rand_%0d got %h/%b want %h/%b",
                 i, rd, ms, erd, ems);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < BYTES; i++) mb[i] = 8'h00;
    rst = 0; we = 0; addr = 0; wdata = 0; f3 = 3'b011;
    @(negedge clk);
    test_reset();
    preload();
    test_word_byte();
    test_partial_stores();
    test_read_first();
    test_reset_store();
    test_misalign();
    test_alias();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
